// File: rtl/core_config_pkg.sv
// Shared opcode, state and sizing definitions for the load/store pipe.
package core_config_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [4:0] {
    c_ADD, c_SUB, c_AND, c_OR,
    c_LB, c_LBU, c_LH, c_LHU, c_LW,
    c_SB, c_SH, c_SW,
    c_LWU, c_LD, c_SD
  } alu_commands_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} lsu_state_t;

  // Doubleword opcodes only exist on a 64-bit datapath.
  function automatic logic is_mem_op(alu_commands_t c, int xlen);
    logic ok;
    ok = 1'b0;
    case (c)
      c_LB, c_LBU, c_LH, c_LHU, c_LW, c_SB, c_SH, c_SW: ok = 1'b1;
      c_LWU, c_LD, c_SD: ok = (xlen == 64);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_store(alu_commands_t c);
    return (c == c_SB) || (c == c_SH) || (c == c_SW) || (c == c_SD);
  endfunction

  function automatic logic op_signed(alu_commands_t c);
    return (c == c_LB) || (c == c_LH) || (c == c_LW);
  endfunction

  function automatic logic [3:0] op_bytes(alu_commands_t c);
    logic [3:0] n;
    n = 4'd0;
    case (c)
      c_LB, c_LBU, c_SB: n = 4'd1;
      c_LH, c_LHU, c_SH: n = 4'd2;
      c_LW, c_LWU, c_SW: n = 4'd4;
      c_LD, c_SD:        n = 4'd8;
      default:           n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; rdata shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit: command queue feeding a one-outstanding-transaction
// memory FSM with alignment checks, lane steering and a response timeout.
module lsu_pipe
  import core_config_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       arg0,
  input  logic [XLEN-1:0]       arg1,
  input  logic [XLEN-1:0]       imm,
  input  alu_commands_t         cmd,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  i_error,
  output logic [XLEN-1:0]       res,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  valid,
  output logic                  o_error,
  input  logic                  clear,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN/8-1:0]     mem_byteen,
  output logic                  mem_we,
  output logic                  mem_req,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic                  mem_err,
  input  logic [XLEN-1:0]       mem_rdata,
  output lsu_state_t            dbg_state
);
  localparam int NB    = XLEN / 8;
  localparam int LB_W  = $clog2(NB);
  localparam int IDX_W = $clog2(XLEN);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    alu_commands_t         cmd;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       data;
  } entry_t;

  // Handshakes: a command transfers on a rising edge where in_valid & in_ready
  // & !i_error; memory requests hold until a cycle with mem_req & mem_gnt;
  // a result stays presented (valid) until the edge that samples clear high.
  entry_t push_ent, head;
  logic   full, empty, push, pop, misaligned;
  logic [3:0] head_bytes;
  logic [2:0] head_mask;

  assign i_error  = in_valid && !is_mem_op(cmd, XLEN);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !i_error;
  assign push_ent = '{cmd: cmd, rd: i_rd, addr: arg0 + imm, data: arg1};

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wdata(push_ent), .rdata(head), .full(full), .empty(empty)
  );

  lsu_state_t            state_q, state_d;
  alu_commands_t         cmd_q, cmd_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign pop        = (state_q == S_IDLE) && !empty;
  assign head_bytes = op_bytes(head.cmd);
  assign head_mask  = 3'(head_bytes - 4'd1);
  assign misaligned = |(head.addr[2:0] & head_mask);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (!empty) begin
        cmd_d   = head.cmd;
        rd_d    = head.rd;
        addr_d  = head.addr;
        wdata_d = head.data;
        rdata_d = '0;
        err_d   = misaligned;
        state_d = misaligned ? S_OUT : S_REQ;
      end
      S_REQ: if (mem_gnt) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          err_d   = mem_err;
          state_d = S_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: if (clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= alu_commands_t'('0);
      rd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [LB_W-1:0] lane;
  logic [3:0]      nb;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] repl, shifted, low_mask, load_val;
  logic [6:0]      msb_idx;
  logic            sgn, in_req, in_out;

  assign lane      = addr_q[LB_W-1:0];
  assign nb        = op_bytes(cmd_q);
  assign size_mask = NB'((16'd1 << nb) - 16'd1);
  assign in_req    = (state_q == S_REQ);
  assign in_out    = (state_q == S_OUT);

  always_comb begin
    case (nb)
      4'd1:    repl = {NB{wdata_q[7:0]}};
      4'd2:    repl = {(NB/2){wdata_q[15:0]}};
      4'd4:    repl = {(NB/4){wdata_q[31:0]}};
      default: repl = wdata_q;
    endcase
  end

  // Right-justify the addressed lanes, then extend from the access width.
  assign shifted  = rdata_q >> {lane, 3'b000};
  assign low_mask = (nb >= 4'(NB)) ? '1 : ((XLEN'(1) << {nb, 3'b000}) - XLEN'(1));
  assign msb_idx  = {nb, 3'b000} - 7'd1;
  assign sgn      = op_signed(cmd_q) && shifted[msb_idx[IDX_W-1:0]];
  assign load_val = (shifted & low_mask) | ({XLEN{sgn}} & ~low_mask);

  assign mem_req    = in_req;
  assign mem_we     = in_req && is_store(cmd_q);
  assign mem_addr   = in_req ? {addr_q[XLEN-1:LB_W], LB_W'(0)} : '0;
  assign mem_byteen = in_req ? (size_mask << lane) : '0;
  assign mem_wdata  = in_req ? repl : '0;

  assign valid     = in_out;
  assign o_error   = in_out && err_q;
  assign o_rd      = in_out ? rd_q : '0;
  assign res       = (in_out && !err_q && !is_store(cmd_q)) ? load_val : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Randomized and directed bench for lsu_pipe against a byte-array memory model.
module tb_lsu_pipe;
  import core_config_pkg::*;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;
  localparam int RW      = 1 + REG_ADDR_W + XLEN;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, i_error, valid, o_error, clear;
  logic [XLEN-1:0] arg0, arg1, imm, res, mem_addr, mem_wdata, mem_rdata;
  alu_commands_t cmd;
  logic [REG_ADDR_W-1:0] i_rd, o_rd;
  logic [3:0] mem_byteen;
  logic mem_we, mem_req, mem_gnt, mem_rvalid, mem_err;
  lsu_state_t dbg_state;

  lsu_pipe #(.XLEN(XLEN), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .arg0(arg0), .arg1(arg1), .imm(imm), .cmd(cmd), .i_rd(i_rd),
    .i_error(i_error), .res(res), .o_rd(o_rd), .valid(valid), .o_error(o_error),
    .clear(clear), .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_we(mem_we),
    .mem_req(mem_req), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  logic in_valid_w, in_ready_w, i_error_w, valid_w, o_error_w, clear_w;
  logic [63:0] arg0_w, arg1_w, imm_w, res_w, mem_addr_w, mem_wdata_w, mem_rdata_w;
  alu_commands_t cmd_w;
  logic [REG_ADDR_W-1:0] i_rd_w, o_rd_w;
  logic [7:0] mem_byteen_w;
  logic mem_we_w, mem_req_w, mem_gnt_w, mem_rvalid_w, mem_err_w;
  lsu_state_t dbg_state_w;

  lsu_pipe #(.XLEN(64), .DEPTH(2), .TIMEOUT(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .arg0(arg0_w), .arg1(arg1_w), .imm(imm_w), .cmd(cmd_w), .i_rd(i_rd_w),
    .i_error(i_error_w), .res(res_w), .o_rd(o_rd_w), .valid(valid_w),
    .o_error(o_error_w), .clear(clear_w), .mem_addr(mem_addr_w),
    .mem_byteen(mem_byteen_w), .mem_we(mem_we_w), .mem_req(mem_req_w),
    .mem_wdata(mem_wdata_w), .mem_gnt(mem_gnt_w), .mem_rvalid(mem_rvalid_w),
    .mem_err(mem_err_w), .mem_rdata(mem_rdata_w), .dbg_state(dbg_state_w)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [RW-1:0] exp_q[$];
  logic [7:0] ref_b [64];
  logic [7:0] resp_b [64];
  logic exp_tmo = 1'b0;
  logic err_en  = 1'b0;

  function automatic int op_size(alu_commands_t c);
    int n;
    n = 0;
    case (c)
      c_LB, c_LBU, c_SB: n = 1;
      c_LH, c_LHU, c_SH: n = 2;
      c_LW, c_SW:        n = 4;
      default:           n = 0;
    endcase
    return n;
  endfunction

  task automatic model(alu_commands_t c, logic [31:0] a, logic [31:0] d, logic [4:0] rd);
    int n, off;
    logic [63:0] v;
    logic err, st;
    n   = op_size(c);
    off = int'(a[5:0]);
    st  = (c == c_SB) || (c == c_SH) || (c == c_SW);
    err = (int'(a[1:0]) % n) != 0;
    v   = 64'd0;
    if (!err && st)
      for (int i = 0; i < n; i++) ref_b[off+i] = d[8*i +: 8];
    if (!err) err = exp_tmo | err_en;
    if (!err && !st) begin
      for (int i = 0; i < n; i++) v = v | (64'(ref_b[off+i]) << (8*i));
      if (((c == c_LB) || (c == c_LH)) && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    end
    exp_q.push_back({err, rd, v[31:0]});
  endtask

  // ---------------- memory responder ----------------
  logic resp_en = 1'b1;
  logic rv_en   = 1'b1;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  int req_cycles = 0;

  always @(negedge clk) if (mem_req) req_cycles++;

  initial begin : responder
    int gnt_wait, rv_wait, wb;
    logic rv_pending, rv_err;
    logic [31:0] rv_data;
    gnt_wait = 0; rv_wait = 0; rv_pending = 1'b0; rv_err = 1'b0; rv_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      if (rst) begin
        rv_pending = 1'b0;
      end else if (rv_pending) begin
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1; mem_rdata = rv_data; mem_err = rv_err; rv_pending = 1'b0;
        end else rv_wait--;
      end else if (mem_req && resp_en) begin
        if (gnt_wait == 0) begin
          mem_gnt = 1'b1;
          last_be = mem_byteen;
          last_wd = mem_wdata;
          wb = int'(mem_addr[5:0]);
          for (int l = 0; l < 4; l++) begin
            rv_data[8*l +: 8] = resp_b[wb+l];
            if (mem_we && mem_byteen[l]) resp_b[wb+l] = mem_wdata[8*l +: 8];
          end
          rv_pending = rv_en;
          rv_err     = err_en;
          rv_wait    = $urandom_range(0, 2);
          gnt_wait   = $urandom_range(0, 3);
        end else gnt_wait--;
      end
    end
  end

  // ---------------- result collector / scoreboard ----------------
  logic [31:0] last_res;
  logic        last_err;

  initial begin : collector
    int hold;
    logic [RW-1:0] e;
    hold = 0; clear = 1'b0; last_res = '0; last_err = 1'b0;
    forever begin
      @(negedge clk);
      clear = 1'b0;
      if (valid && !rst) begin
        if (hold > 0) hold--;
        else begin
          check("exp_pending", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result", 64'({o_error, o_rd, res}), 64'(e));
          end
          last_res = res; last_err = o_error;
          clear = 1'b1;
          hold = $urandom_range(0, 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(alu_commands_t c, logic [31:0] base, logic [31:0] off,
                       logic [31:0] d, logic [4:0] rd);
    int n;
    logic acc;
    @(negedge clk);
    cmd = c; arg0 = base; imm = off; arg1 = d; i_rd = rd; in_valid = 1'b1;
    #1;
    if (op_size(c) == 0) begin
      check("i_error_set", 64'(i_error), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    check("i_error_clr", 64'(i_error), 64'd0);
    n = 0;
    while (!in_ready && n < 400) begin @(negedge clk); n++; end
    acc = in_ready;
    check("issue_ready", 64'(acc), 64'd1);
    @(posedge clk);
    if (acc) model(c, base + off, d, rd);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("drain_idle", 64'(dbg_state), 64'(S_IDLE));
  endtask

  task automatic run64(alu_commands_t c, logic [63:0] a, logic [63:0] rdata,
                       output logic [63:0] r, output logic [63:0] addr_seen,
                       output logic [7:0] be_seen);
    int n;
    @(negedge clk);
    cmd_w = c; arg0_w = a; imm_w = '0; arg1_w = 64'h0123_4567_89AB_CDEF; i_rd_w = 5'd9;
    in_valid_w = 1'b1;
    #1 check("w_i_error", 64'(i_error_w), 64'd0);
    @(posedge clk);
    #1 in_valid_w = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_req_w && n < 20) begin @(negedge clk); n++; end
    check("w_req", 64'(mem_req_w), 64'd1);
    addr_seen = mem_addr_w; be_seen = mem_byteen_w;
    mem_gnt_w = 1'b1;
    @(negedge clk);
    mem_gnt_w = 1'b0; mem_rvalid_w = 1'b1; mem_rdata_w = rdata;
    @(negedge clk);
    mem_rvalid_w = 1'b0;
    check("w_valid", 64'(valid_w), 64'd1);
    r = res_w;
    clear_w = 1'b1;
    @(negedge clk);
    clear_w = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    alu_commands_t pick [10];
    logic [63:0] r64, a64;
    logic [7:0] be64;
    logic [31:0] base;
    int seen, n, k, r0;
    pick = '{c_LB, c_LBU, c_LH, c_LHU, c_LW, c_SB, c_SH, c_SW, c_ADD, c_LD};

    in_valid = 1'b0; cmd = c_ADD; arg0 = '0; arg1 = '0; imm = '0; i_rd = '0;
    in_valid_w = 1'b0; cmd_w = c_ADD; arg0_w = '0; arg1_w = '0; imm_w = '0; i_rd_w = '0;
    clear_w = 1'b0; mem_gnt_w = 1'b0; mem_rvalid_w = 1'b0; mem_err_w = 1'b0; mem_rdata_w = '0;
    for (int i = 0; i < 64; i++) begin
      ref_b[i] = 8'($urandom);
      resp_b[i] = ref_b[i];
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_outs", 64'({o_error, o_rd, res}), 64'd0);
    check("rst_mem", 64'({mem_req, mem_we, mem_byteen}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Store word: latency and lane enables.
    issue(c_SW, 32'h100, 32'h0, 32'hDEADBEEF, 5'd1);
    check("lat_accept_edge", 64'(mem_req), 64'd0);
    @(posedge clk);
    #1 check("lat_req", 64'(mem_req), 64'd1);
    drain();
    check("sw_byteen", 64'(last_be), 64'hF);
    check("sw_wdata", 64'(last_wd), 64'hDEADBEEF);
    check("sw_res", 64'(last_res), 64'd0);

    // Byte loads with sign and zero extension.
    issue(c_SW, 32'hF0, 32'h10, 32'h80FFFFFF, 5'd2);
    issue(c_LB, 32'h100, 32'h3, 32'h0, 5'd3);
    drain();
    check("lb_res", 64'(last_res), 64'hFFFFFF80);
    issue(c_LBU, 32'h103, 32'h0, 32'h0, 5'd4);
    drain();
    check("lbu_res", 64'(last_res), 64'h00000080);

    // Misaligned halfword never reaches the bus.
    r0 = req_cycles;
    issue(c_LH, 32'h101, 32'h0, 32'h0, 5'd5);
    drain();
    check("mis_no_req", 64'(req_cycles - r0), 64'd0);
    check("mis_err", 64'(last_err), 64'd1);
    check("mis_res", 64'(last_res), 64'd0);

    // Illegal opcodes at XLEN=32.
    issue(c_LD, 32'h100, 32'h0, 32'h0, 5'd6);
    issue(c_ADD, 32'h100, 32'h0, 32'h0, 5'd6);

    // Queue full with grants withheld: one command sits in the FSM, four in the queue.
    resp_en = 1'b0;
    for (int i = 0; i < 5; i++) issue(c_LW, 32'h100, 32'(4*i), 32'h0, 5'(10+i));
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_state", 64'(dbg_state), 64'(S_REQ));
    @(negedge clk);
    cmd = c_LW; arg0 = 32'h118; imm = '0; i_rd = 5'd15; in_valid = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (in_ready) seen++; end
    in_valid = 1'b0;
    check("full_held", 64'(seen), 64'd0);
    resp_en = 1'b1;
    issue(c_LW, 32'h118, 32'h0, 32'h0, 5'd15);
    drain();

    // Response timeout.
    rv_en = 1'b0; exp_tmo = 1'b1;
    issue(c_LW, 32'h108, 32'h0, 32'h0, 5'd7);
    exp_tmo = 1'b0;
    n = 0;
    while (dbg_state != S_WAIT && n < 50) begin @(negedge clk); n++; end
    k = 0;
    while (dbg_state == S_WAIT && k < 100) begin k++; @(negedge clk); end
    check("timeout_cycles", 64'(k), 64'(TIMEOUT));
    check("timeout_err", 64'(o_error), 64'd1);
    rv_en = 1'b1;
    drain();

    // Bus error response.
    err_en = 1'b1;
    issue(c_LW, 32'h10C, 32'h0, 32'h0, 5'd8);
    drain();
    err_en = 1'b0;
    check("memerr_err", 64'(last_err), 64'd1);

    // Random traffic with wrapping address arithmetic.
    for (int t = 0; t < 200; t++) begin
      base = $urandom;
      issue(pick[$urandom_range(0, 9)], base, 32'h100 + 32'($urandom_range(0, 63)) - base,
            $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 64; i++) check("mem_image", 64'(resp_b[i]), 64'(ref_b[i]));

    // Reset while a request is pending.
    resp_en = 1'b0;
    issue(c_LW, 32'h100, 32'h0, 32'h0, 5'd3);
    n = 0;
    while (dbg_state != S_REQ && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_req", 64'(mem_req), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    resp_en = 1'b1;
    r0 = req_cycles;
    repeat (6) @(negedge clk);
    check("mid_rst_quiet", 64'(req_cycles - r0), 64'd0);

    // 64-bit datapath.
    run64(c_LWU, 64'h104, 64'h89ABCDEF_00000000, r64, a64, be64);
    check("w_lwu_res", r64, 64'h0000000089ABCDEF);
    check("w_lwu_addr", a64, 64'h100);
    check("w_lwu_be", 64'(be64), 64'hF0);
    run64(c_LW, 64'h104, 64'h89ABCDEF_00000000, r64, a64, be64);
    check("w_lw_res", r64, 64'hFFFFFFFF89ABCDEF);
    run64(c_SD, 64'h108, 64'h0, r64, a64, be64);
    check("w_sd_be", 64'(be64), 64'hFF);
    check("w_sd_res", r64, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
